// File: rtl/fetch_pkg.sv
// Shared types and address-split helpers for the fetch stage and its instruction cache.
package fetch_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [0:0] {
        LOOKUP = 1'b0,
        REFILL = 1'b1
    } fetch_state_e;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag covers whatever remains of the 30-bit word address above offset and index.
    function automatic int tag_w(input int lines, input int words);
        return 30 - $clog2(lines) - $clog2(words);
    endfunction

    // The beat counter keeps at least one bit even for single-word lines.
    function automatic int cnt_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/fetch_icache_array.sv
// Direct-mapped instruction cache storage: resettable valid bits, plus tag and data RAMs
// that are never reset. Provides one refill write port and a combinational read port.
module icache_array
    import fetch_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    localparam int IDX_W         = idx_w(LINES),
    localparam int TAG_W         = tag_w(LINES, WORDS_PER_LINE),
    localparam int CNT_W         = cnt_w(WORDS_PER_LINE)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [CNT_W-1:0]   wr_off,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               tag_we,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               validate,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic [CNT_W-1:0]   rd_off,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [INSTR_W-1:0] rd_data
);

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   valid_d;
    logic [INSTR_W-1:0] data_q [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]   tag_q  [LINES];

    // Next valid vector: flush wipes every line and wins over a same-cycle validate.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (validate) begin
            valid_d[wr_idx] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bit register, the only cache state cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data RAM write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx][wr_off] <= wr_data;
        end
        if (tag_we) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/fetch_icache.sv
// Instruction-fetch stage: PC register, direct-mapped cache lookup with zero-latency hits,
// and a line-refill state machine that streams a whole line from memory on a miss.
module fetch_icache
    import fetch_pkg::*;
#(
    parameter int          LINES          = 16,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               pc_source,
    input  logic [31:0]        branch_target,
    input  logic               flush,
    output logic               hit,
    output logic [31:0]        next_pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_rdata
);

    localparam int OFF_W = off_w(WORDS_PER_LINE);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES, WORDS_PER_LINE);
    localparam int CNT_W = cnt_w(WORDS_PER_LINE);
    localparam logic [31:0]      LINE_MASK = 32'(WORDS_PER_LINE * 4 - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_LINE - 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             kill_q, kill_d;
    logic             mem_req_q, mem_req_d;

    logic [29:0]        pc_word_s;
    logic [CNT_W-1:0]   pc_off_s;
    logic [IDX_W-1:0]   pc_idx_s;
    logic [TAG_W-1:0]   pc_tag_s;
    logic [IDX_W-1:0]   base_idx_s;
    logic [TAG_W-1:0]   base_tag_s;
    logic               rd_valid_s;
    logic [TAG_W-1:0]   rd_tag_s;
    logic [INSTR_W-1:0] rd_data_s;
    logic               lookup_hit_s;
    logic               redirect_s;
    logic               beat_s;
    logic               last_beat_s;
    logic               validate_s;
    logic [31:0]        target_s;

    assign pc_word_s  = pc_q[31:2];
    assign pc_off_s   = CNT_W'(pc_word_s & 30'(WORDS_PER_LINE - 1));
    assign pc_idx_s   = IDX_W'(pc_word_s >> OFF_W);
    assign pc_tag_s   = TAG_W'(pc_word_s >> (OFF_W + IDX_W));
    // The refill targets the latched line base, so a redirect mid-refill cannot retarget it.
    assign base_idx_s = IDX_W'(base_q >> (OFF_W + 2));
    assign base_tag_s = TAG_W'(base_q >> (OFF_W + IDX_W + 2));
    assign target_s   = branch_target & 32'hFFFF_FFFC;

    assign redirect_s   = pc_source && !stall;
    assign lookup_hit_s = (state_q == LOOKUP) && rd_valid_s && (rd_tag_s == pc_tag_s) && !flush;
    assign beat_s       = (state_q == REFILL) && mem_req_q && mem_ready;
    assign last_beat_s  = beat_s && (cnt_q == LAST_BEAT);
    assign validate_s   = last_beat_s && !kill_q && !flush;

    icache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .wr_en    (beat_s),
        .wr_idx   (base_idx_s),
        .wr_off   (cnt_q),
        .wr_data  (mem_rdata),
        .tag_we   (last_beat_s),
        .wr_tag   (base_tag_s),
        .validate (validate_s),
        .rd_idx   (pc_idx_s),
        .rd_off   (pc_off_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s)
    );

    assign hit         = lookup_hit_s;
    assign instruction = lookup_hit_s ? rd_data_s : {INSTR_W{1'b0}};
    assign next_pc     = pc_q + 32'd4;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    // Next-state logic for the PC, the refill FSM, beat counter, kill flag and memory request.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        kill_d     = kill_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;

        if (redirect_s) begin
            pc_d = target_s;
        end else if (lookup_hit_s && !stall) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        case (state_q)
            LOOKUP: begin
                kill_d = 1'b0;
                if (!lookup_hit_s && !redirect_s) begin
                    state_d    = REFILL;
                    base_d     = pc_q & ~LINE_MASK;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q & ~LINE_MASK;
                end else begin
                    state_d = LOOKUP;
                end
            end
            REFILL: begin
                if (flush) begin
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
                if (last_beat_s) begin
                    state_d    = LOOKUP;
                    kill_d     = 1'b0;
                    cnt_d      = '0;
                    mem_req_d  = 1'b0;
                    mem_addr_d = 32'd0;
                end else if (beat_s) begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    mem_addr_d = mem_addr_q + 32'd4;
                end else begin
                    cnt_d      = cnt_q;
                    mem_addr_d = mem_addr_q;
                end
            end
            default: begin
                state_d   = LOOKUP;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Fetch state register; reset drops mem_req immediately and restarts at RESET_PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOOKUP;
            pc_q       <= RESET_PC;
            base_q     <= 32'd0;
            cnt_q      <= '0;
            kill_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            kill_q     <= kill_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

endmodule

// File: tb/tb_fetch_icache.sv
// Scoreboard bench for fetch_icache: directed scenarios push expected refill beats and
// consumed hits into queues; a negedge monitor pops and compares them against the DUT.
module tb_fetch_icache;

    localparam int LINES = 32;
    localparam int WPL   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        pc_source = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        flush = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_rdata;
    logic        hit;
    logic [31:0] next_pc;
    logic [31:0] instruction;
    logic        mem_req;
    logic [31:0] mem_addr;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_beat_q[$];
    logic [63:0] exp_hit_q[$];

    fetch_icache #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL),
        .RESET_PC       (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .pc_source     (pc_source),
        .branch_target (branch_target),
        .flush         (flush),
        .hit           (hit),
        .next_pc       (next_pc),
        .instruction   (instruction),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: word at address a holds a ^ 32'hA5A5_0000.
    assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Monitor: refill beats and consumed hits are checked against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) begin
                if (exp_beat_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat addr=%h expected no request", mem_addr);
                end else if (mem_ready) begin
                    chk("beat_addr", mem_addr, exp_beat_q.pop_front());
                end else begin
                    chk("beat_hold", mem_addr, exp_beat_q[0]);
                end
            end
            if (hit && !stall) begin
                if (exp_hit_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_hit instr=%h expected no hit", instruction);
                end else begin
                    logic [63:0] e;
                    e = exp_hit_q.pop_front();
                    chk("hit_instr", instruction, e[63:32]);
                    chk("hit_next_pc", next_pc, e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_hit(input string nm, input logic e);
        @(negedge clk);
        chk(nm, 32'(hit), 32'(e));
    endtask

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < WPL; i++) exp_beat_q.push_back(base + 32'(4 * i));
    endtask

    task automatic push_hit(input logic [31:0] pc);
        exp_hit_q.push_back({pc ^ 32'hA5A5_0000, pc + 32'd4});
    endtask

    // Pulse reset; on return the bench is in cycle 0 (first LOOKUP at pc=0, cache cold).
    task automatic restart();
        rst_n = 1'b0;
        stall = 1'b0;
        pc_source = 1'b0;
        flush = 1'b0;
        mem_ready = 1'b1;
        branch_target = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        tick();
        chk({nm, "_beats_left"}, 32'(exp_beat_q.size()), 32'd0);
        chk({nm, "_hits_left"}, 32'(exp_hit_q.size()), 32'd0);
        exp_beat_q.delete();
        exp_hit_q.delete();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_next_pc", next_pc, 32'd4);

        // Cold start: miss at c0, beats 0,4,8,C at c1..c4, hits 0,4,8,C at c5..c8.
        restart();
        push_line(32'h0);
        push_hit(32'h0); push_hit(32'h4); push_hit(32'h8); push_hit(32'hC);
        expect_hit("a_c0_miss", 1'b0);
        chk("a_c0_no_req", 32'(mem_req), 32'd0);
        run(4);
        expect_hit("a_c4_no_hit", 1'b0);
        run(1);
        expect_hit("a_c5_first_hit", 1'b1);
        run(3);
        pc_source = 1'b1; branch_target = 32'h0;
        run(1);
        pc_source = 1'b0; stall = 1'b1;
        expect_hit("a_park_hit", 1'b1);
        chk("a_park_instr", instruction, 32'hA5A5_0000);
        drain("a");

        // Back-pressure: mem_ready 1,0,1,0,... from c0; last beat at c8, hit at c9 (2W+1).
        restart();
        push_line(32'h0);
        push_hit(32'h0);
        for (int k = 0; k <= 8; k++) begin
            mem_ready = (k % 2 == 0) ? 1'b1 : 1'b0;
            if (k == 8) expect_hit("c_c8_no_hit", 1'b0);
            tick();
        end
        mem_ready = 1'b1;
        expect_hit("c_c9_hit", 1'b1);
        tick();
        stall = 1'b1;
        expect_hit("c_stall_hit", 1'b1);
        chk("c_stall_instr", instruction, 32'hA5A5_0004);
        tick();
        @(negedge clk);
        chk("c_stall_instr_held", instruction, 32'hA5A5_0004);
        chk("c_stall_pc_held", next_pc, 32'h8);
        drain("c");

        // Redirect to 0x103 during beat 2: line 0 completes, 0x100 then misses and refills.
        restart();
        push_line(32'h0);
        run(3);
        pc_source = 1'b1; branch_target = 32'h103;
        run(1);
        pc_source = 1'b0;
        run(1);
        expect_hit("b_target_miss", 1'b0);
        chk("b_target_pc", next_pc, 32'h104);
        push_line(32'h100);
        push_hit(32'h100);
        run(5);
        pc_source = 1'b1; branch_target = 32'h0;
        push_hit(32'h0);
        run(1);
        pc_source = 1'b0;
        expect_hit("b_refetch_hit", 1'b1);
        tick();
        stall = 1'b1;
        drain("b");

        // Conflict: 0x200 shares index 0 with 0x0, so each switch re-misses.
        restart();
        push_line(32'h0);
        push_hit(32'h0);
        run(5);
        pc_source = 1'b1; branch_target = 32'h200;
        run(1);
        pc_source = 1'b0;
        expect_hit("d_conflict_miss", 1'b0);
        push_line(32'h200);
        push_hit(32'h200);
        run(5);
        pc_source = 1'b1; branch_target = 32'h0;
        run(1);
        pc_source = 1'b0;
        expect_hit("d_return_miss", 1'b0);
        push_line(32'h0);
        push_hit(32'h0);
        run(5);
        tick();
        stall = 1'b1;
        drain("d");

        // Flush on the last beat, flush in LOOKUP, and flush mid-refill (kill).
        restart();
        stall = 1'b1;
        push_line(32'h0);
        run(4);
        flush = 1'b1;
        run(1);
        flush = 1'b0;
        expect_hit("e_last_beat_flush_remiss", 1'b0);
        push_line(32'h0);
        run(5);
        expect_hit("e_refilled_hit", 1'b1);
        run(1);
        flush = 1'b1;
        expect_hit("e_lookup_flush_hit0", 1'b0);
        push_line(32'h0);
        run(1);
        flush = 1'b0;
        run(1);
        flush = 1'b1;
        run(1);
        flush = 1'b0;
        run(2);
        expect_hit("e_killed_line_remiss", 1'b0);
        push_line(32'h0);
        run(5);
        expect_hit("e_final_hit", 1'b1);
        drain("e");

        // Reset between beats: mem_req drops at once, line re-misses after release.
        restart();
        exp_beat_q.push_back(32'h0);
        exp_beat_q.push_back(32'h4);
        run(3);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("f_req_async_drop", 32'(mem_req), 32'd0);
        restart();
        expect_hit("f_post_reset_miss", 1'b0);
        chk("f_post_reset_pc", next_pc, 32'h4);
        push_line(32'h0);
        push_hit(32'h0);
        run(5);
        tick();
        stall = 1'b1;
        drain("f");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/fetch_icache.md
# fetch_icache

Parametrised instruction-fetch stage with an integrated direct-mapped instruction cache and a line-refill state machine. It holds the PC and looks the PC up in the cache. On a hit it presents the instruction and the sequential PC in the same cycle. On a miss it refills the whole line from instruction memory over a req/ready handshake. It sits between the branch-resolution logic (pc_source/branch_target) and the decode stage, with memory behind it.

## Interface
- LINES, 16, number of cache lines; power of two, ≥2
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, ≥1
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  decode back-pressure; holds the PC, refill continues
- pc_source  in  1  1 = redirect the PC to branch_target
- branch_target  in  32  redirect address; bits [1:0] ignored and treated as 0
- flush  in  1  invalidate every cache line
- hit  out  1  instruction output is valid this cycle
- next_pc  out  32  pc + 4, modulo 2^32
- instruction  out  32  cached word at pc when hit=1, otherwise 0
- mem_req  out  1  refill beat request
- mem_addr  out  32  word address of the current refill beat
- mem_ready  in  1  beat accepted; mem_rdata is valid in this cycle
- mem_rdata  in  32  refill data

## Operation
- Address split: pc[1:0] is the byte offset. The next log2(WORDS_PER_LINE) bits are the word offset, the next log2(LINES) bits are the index, and the remaining bits are the tag.
- States:
  - LOOKUP: hit = valid[idx] && tag[idx]==pc tag.
  - LOOKUP, hit=0, no redirect this cycle: latch line base = {pc tag, idx, 0s}, clear the beat counter, go to REFILL.
  - REFILL: mem_req=1 and mem_addr = base + 4*cnt. On mem_ready, write mem_rdata into word cnt of line idx and increment cnt. On the last beat, write the tag, set valid (unless the flush-kill flag is set), and go to LOOKUP.
- PC update:
  - If pc_source=1 and stall=0, pc <= {branch_target[31:2],2'b00}. This applies in any state.
  - Otherwise, if hit=1 and stall=0, pc <= pc + 4.
  - Otherwise pc holds.
- A redirect during REFILL does not abort the refill. The line still completes. LOOKUP then checks the new PC.
- In REFILL, hit=0 and instruction=0.
- flush:
  - Clears all valid bits in one cycle.
  - During REFILL it sets a kill flag. The refill still completes, but the line is left invalid.
  - flush on the same cycle as the last beat leaves the line invalid.
  - The kill flag clears on entry to LOOKUP.
  - In LOOKUP, hit is forced to 0 in the cycle flush is asserted.
- flush and pc_source in the same cycle: both take effect.
- mem_ready while mem_req=0 is ignored.
- Tag and data arrays are not reset. Only the valid bits are reset.

## Timing
- Values on reset: pc=RESET_PC, state=LOOKUP, all valid=0, cnt=0, kill=0.
- Outputs during reset: hit=0, instruction=0, mem_req=0, mem_addr=0, next_pc=RESET_PC+4.
- Reset asserted mid-refill: mem_req drops asynchronously, and the partial line stays invalid.
- Hit latency is 0. hit, instruction and next_pc are combinational from the registered pc and the arrays.
- Miss timeline with mem_ready tied to 1:
  - Cycle t: miss detected.
  - Cycles t+1 to t+W: REFILL beats.
  - Cycle t+W+1: hit.
  - Total penalty: W+1 cycles.
- Each mem_ready wait cycle adds one cycle. mem_req, mem_addr and cnt are stable while mem_ready=0.
- At the top of memory, pc + 4 wraps to 0. Refill addresses never cross a line boundary.

## Structure
- Package fetch_pkg holds:
  - the state enum (LOOKUP, REFILL);
  - INSTR_W = 32;
  - helper functions for the tag, index and offset widths as a function of the parameters.
- Sub-module icache_array holds:
  - valid bits, with async clear on rst_n and sync clear on flush;
  - the tag RAM;
  - the data RAM;
  - one write port (word write plus a line-validate strobe);
  - a combinational read port.
- fetch_icache holds the PC, the FSM, the beat counter, the kill flag and the memory handshake.

## Test plan
- Cold start, RESET_PC=0, mem_ready=1, memory word at address a = a ^ 32'hA5A5_0000 -> mem_addr steps 0,4,8,C. The first hit is at cycle 5 with instruction=32'hA5A5_0000. The next three cycles hit back-to-back with pc 4,8,C.
- Redirect during refill: pc_source=1, branch_target=32'h100 at beat 2 -> the line for 0x00 still completes. The next lookup misses on 0x100 and refills 0x100 to 0x10C. After that, a re-fetch of 0x0 hits.
- Back-pressure: mem_ready toggling 1,0,1,0 -> mem_addr is held during the 0 cycles and the penalty is 2W+1. stall=1 on a hit -> pc and instruction are held, with no advance.
- Conflict: fetch 0x0, then redirect to 0x0 + LINES*WORDS_PER_LINE*4 (same index, different tag) -> miss and refill. Redirect back to 0x0 -> miss again.
- Flush: flush on the last refill beat -> the line stays invalid and the next lookup re-misses. Flush in LOOKUP -> hit=0 that cycle and all lines re-miss.
- Reset mid-refill (rst_n low between beats) -> mem_req=0 immediately, pc=RESET_PC after release, and the line re-misses.
